// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: Tuse codes, forwarding-select codes, stage record struct,
// default multiply/divide busy lengths, saturating decrement and match helper.
package hazard_ctrl_pkg;

  // Stage in which a D-stage source operand is first consumed.
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Bypass mux selects.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // One pipeline stage's view of the instruction it holds. M and W carry
  // the full record so the shift is uniform; they only consume a subset.
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md_start;
    logic       md_div;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Register 0 is hard-wired, so it never produces a dependency.
  function automatic logic rec_match(input stage_rec_t r, input logic [4:0] s);
    return r.valid && (r.dst != 5'd0) && (r.dst == s);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decode bundle into the hazard controller and its decisions back out.
// Latency: n/a (wires only).
// Backpressure: stall is the only flow-control signal; it holds PC and IF/ID.
// master: decoder/datapath side (drives decode, reads selects).
// slave:  hazard_ctrl (reads decode, drives stall/selects/md_busy).
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] dst_d;
  logic [1:0] tnew_d;
  logic       md_start_d;
  logic       md_div_d;
  logic       md_use_d;

  logic       stall;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic       fwd_rt_m;
  logic       md_busy;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter: loads the op length when a start leaves E.
// Latency: busy rises the cycle after the start leaves E, stays high N cycles.
// Backpressure: none here; the caller gates new starts with busy.
// Ports: clk, rst_n, start (E holds md start), div (start is a divide), busy.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall, bypass selects, md busy.
// Latency: stall and selects are combinational from D decode + E/M/W records.
// Backpressure: stall holds PC and IF/ID and injects a bubble into ID/EX.
// Ports: clk, rst_n (async, active low), hif (slave: D decode in, decisions out).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);

  stage_rec_t rec_d;
  stage_rec_t rec_e;
  stage_rec_t rec_m;
  stage_rec_t rec_w;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;
  logic md_busy;

  // A source stalls while an older producer in E or M will still not have
  // its result ready by the stage that consumes the operand.
  function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse,
                                      input stage_rec_t e, input stage_rec_t m);
    return (tuse != TUSE_NONE) &&
           ((rec_match(e, s) && (e.tnew > tuse)) ||
            (rec_match(m, s) && (m.tnew > tuse)));
  endfunction

  // Youngest ready producer wins; W is always ready.
  function automatic logic [1:0] fwd_for_d(input logic [4:0] s, input stage_rec_t e,
                                           input stage_rec_t m, input stage_rec_t w);
    if (rec_match(e, s) && (e.tnew == 2'd0)) return FWD_E;
    if (rec_match(m, s) && (m.tnew == 2'd0)) return FWD_M;
    if (rec_match(w, s))                      return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_for_e(input logic [4:0] s, input stage_rec_t m,
                                           input stage_rec_t w);
    if (rec_match(m, s) && (m.tnew == 2'd0)) return FWD_M;
    if (rec_match(w, s))                      return FWD_W;
    return FWD_RF;
  endfunction

  // Record that would enter E; its tnew already accounts for the D->E step.
  always_comb begin
    rec_d          = REC_BUBBLE;
    rec_d.valid    = 1'b1;
    rec_d.dst      = hif.dst_d;
    rec_d.tnew     = sat_dec(hif.tnew_d);
    rec_d.rs       = hif.rs_d;
    rec_d.rt       = hif.rt_d;
    rec_d.md_start = hif.md_start_d;
    rec_d.md_div   = hif.md_div_d;
  end

  assign stall_rs = src_hazard(hif.rs_d, hif.tuse_rs_d, rec_e, rec_m);
  assign stall_rt = src_hazard(hif.rt_d, hif.tuse_rt_d, rec_e, rec_m);
  // A start still in E has not loaded the counter yet, so it blocks too.
  assign stall_md = hif.md_use_d & (md_busy | rec_e.md_start);
  assign stall    = stall_rs | stall_rt | stall_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_e <= REC_BUBBLE;
      rec_m <= REC_BUBBLE;
      rec_w <= REC_BUBBLE;
    end else begin
      rec_w      <= rec_m;
      rec_w.tnew <= sat_dec(rec_m.tnew);
      rec_m      <= rec_e;
      rec_m.tnew <= sat_dec(rec_e.tnew);
      rec_e      <= stall ? REC_BUBBLE : rec_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (rec_e.md_start),
    .div   (rec_e.md_div),
    .busy  (md_busy)
  );

  assign hif.stall    = stall;
  assign hif.md_busy  = md_busy;
  assign hif.fwd_rs_d = fwd_for_d(hif.rs_d, rec_e, rec_m, rec_w);
  assign hif.fwd_rt_d = fwd_for_d(hif.rt_d, rec_e, rec_m, rec_w);
  assign hif.fwd_rs_e = fwd_for_e(rec_e.rs, rec_m, rec_w);
  assign hif.fwd_rt_e = fwd_for_e(rec_e.rt, rec_m, rec_w);
  assign hif.fwd_rt_m = rec_match(rec_w, rec_m.rt);

  // Record fields shifted along for uniformity but never consumed.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{rec_m.rs, rec_m.md_start, rec_m.md_div,
                             rec_w.tnew, rec_w.rs, rec_w.rt, rec_w.md_start, rec_w.md_div};

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int NMULT = 5;
  localparam int NDIV  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(
    .MULT_CYCLES (NMULT),
    .DIV_CYCLES  (NDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    bit         md_start, md_div, md_use;
  } instr_t;

  typedef struct {
    bit     valid;
    instr_t i;
  } slot_t;

  typedef struct {
    bit         stall;
    logic [1:0] frs_d, frt_d, frs_e, frt_e;
    bit         frt_m, busy;
  } exp_t;

  // Reference model: the last three issued instructions (index 0 = E,
  // 1 = M, 2 = W) plus the cycle window during which the md unit is busy.
  slot_t  pipe[3];
  int     cyc;
  int     md_beg, md_end;
  instr_t cur;
  bit     cur_stall;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   dut_stall_cnt;
  int   busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction constructors ----------------
  function automatic instr_t nop();
    instr_t x;
    x.rs = 0; x.rt = 0; x.dst = 0; x.tuse_rs = 3; x.tuse_rt = 3; x.tnew = 0;
    x.md_start = 0; x.md_div = 0; x.md_use = 0;
    return x;
  endfunction
  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t x = nop();
    x.dst = 5'(d); x.rs = 5'(s); x.rt = 5'(t); x.tuse_rs = 1; x.tuse_rt = 1; x.tnew = 2;
    return x;
  endfunction
  function automatic instr_t ori(input int d, input int s);
    instr_t x = nop();
    x.dst = 5'(d); x.rs = 5'(s); x.rt = 5'(d); x.tuse_rs = 1; x.tnew = 2;
    return x;
  endfunction
  function automatic instr_t lw(input int d, input int b);
    instr_t x = nop();
    x.dst = 5'(d); x.rs = 5'(b); x.rt = 5'(d); x.tuse_rs = 1; x.tnew = 3;
    return x;
  endfunction
  function automatic instr_t sw(input int data, input int b);
    instr_t x = nop();
    x.rs = 5'(b); x.rt = 5'(data); x.tuse_rs = 1; x.tuse_rt = 2;
    return x;
  endfunction
  function automatic instr_t beq(input int s, input int t);
    instr_t x = nop();
    x.rs = 5'(s); x.rt = 5'(t); x.tuse_rs = 0; x.tuse_rt = 0;
    return x;
  endfunction
  function automatic instr_t jal();
    instr_t x = nop();
    x.dst = 31; x.tnew = 1;
    return x;
  endfunction
  function automatic instr_t jr(input int s);
    instr_t x = nop();
    x.rs = 5'(s); x.tuse_rs = 0;
    return x;
  endfunction
  function automatic instr_t mdop(input bit is_div);
    instr_t x = nop();
    x.rs = 4; x.rt = 5; x.tuse_rs = 1; x.tuse_rt = 1;
    x.md_start = 1; x.md_div = is_div; x.md_use = 1;
    return x;
  endfunction
  function automatic instr_t mflo(input int d);
    instr_t x = nop();
    x.dst = 5'(d); x.tnew = 2; x.md_use = 1;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    int r = $urandom_range(0, 31);
    if (r == 0) begin
      x = mdop(1'($urandom_range(0, 1)));
    end else if (r == 1) begin
      x = mflo($urandom_range(0, 7));
    end else begin
      x = nop();
      x.rs      = 5'($urandom_range(0, 7));
      x.rt      = 5'($urandom_range(0, 7));
      x.dst     = 5'($urandom_range(0, 7));
      x.tuse_rs = 2'($urandom_range(0, 3));
      x.tuse_rt = 2'($urandom_range(0, 3));
      x.tnew    = 2'($urandom_range(0, 3));
    end
    return x;
  endfunction

  // ---------------- reference model ----------------
  // Cycles of latency still outstanding for the producer k+1 stages past D.
  function automatic int remain(input int k);
    int t = int'(pipe[k].i.tnew) - (k + 1);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit hit(input int k, input logic [4:0] s);
    return pipe[k].valid && (s != 5'd0) && (pipe[k].i.dst == s);
  endfunction

  function automatic bit model_busy();
    return (cyc >= md_beg) && (cyc <= md_end);
  endfunction

  function automatic bit src_stall(input logic [4:0] s, input logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (hit(k, s) && remain(k) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_d(input logic [4:0] s);
    if (hit(0, s) && remain(0) == 0) return 2'd1;
    if (hit(1, s) && remain(1) == 0) return 2'd2;
    if (hit(2, s)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] s);
    if (hit(1, s) && remain(1) == 0) return 2'd2;
    if (hit(2, s)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic exp_t predict(input instr_t d);
    exp_t e;
    logic [4:0] ers, ert, mrt;
    ers = pipe[0].valid ? pipe[0].i.rs : 5'd0;
    ert = pipe[0].valid ? pipe[0].i.rt : 5'd0;
    mrt = pipe[1].valid ? pipe[1].i.rt : 5'd0;
    e.busy  = model_busy();
    e.stall = src_stall(d.rs, d.tuse_rs) || src_stall(d.rt, d.tuse_rt) ||
              (d.md_use && (e.busy || (pipe[0].valid && pipe[0].i.md_start)));
    e.frs_d = fwd_d(d.rs);
    e.frt_d = fwd_d(d.rt);
    e.frs_e = fwd_e(ers);
    e.frt_e = fwd_e(ert);
    e.frt_m = hit(2, mrt);
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      pipe[k].valid = 1'b0;
      pipe[k].i     = nop();
    end
    md_beg = 1;
    md_end = 0;
  endfunction

  function automatic void model_advance();
    if (pipe[0].valid && pipe[0].i.md_start) begin
      md_beg = cyc + 1;
      md_end = cyc + (pipe[0].i.md_div ? NDIV : NMULT);
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0].valid = !cur_stall;
    pipe[0].i     = cur;
    cyc++;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input instr_t x);
    hif.rs_d       = x.rs;
    hif.rt_d       = x.rt;
    hif.dst_d      = x.dst;
    hif.tuse_rs_d  = x.tuse_rs;
    hif.tuse_rt_d  = x.tuse_rt;
    hif.tnew_d     = x.tnew;
    hif.md_start_d = x.md_start;
    hif.md_div_d   = x.md_div;
    hif.md_use_d   = x.md_use;
  endtask

  // One clock: advance the model, present D, queue the expectation.
  task automatic step(input instr_t ins, output bit s);
    exp_t e;
    @(posedge clk);
    if (rst_n) model_advance();
    #1;
    drive(ins);
    cur       = ins;
    e         = predict(ins);
    cur_stall = e.stall;
    exp_q.push_back(e);
    s = e.stall;
    #3;
    if (hif.stall)   dut_stall_cnt++;
    if (hif.md_busy) busy_cnt++;
  endtask

  // Hold an instruction in D until the model lets it go; return DUT stall cycles.
  task automatic issue(input instr_t ins, output int n);
    bit s;
    int g = 0;
    dut_stall_cnt = 0;
    do begin
      step(ins, s);
      g++;
    end while (s && g < 60);
    if (s) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: instruction still held after %0d cycles", g);
    end
    n = dut_stall_cnt;
  endtask

  task automatic nops(input int k);
    int n;
    for (int j = 0; j < k; j++) issue(nop(), n);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall",    hif.stall,    e.stall);
      chk("fwd_rs_d", hif.fwd_rs_d, e.frs_d);
      chk("fwd_rt_d", hif.fwd_rt_d, e.frt_d);
      chk("fwd_rs_e", hif.fwd_rs_e, e.frs_e);
      chk("fwd_rt_e", hif.fwd_rt_e, e.frt_e);
      chk("fwd_rt_m", hif.fwd_rt_m, e.frt_m);
      chk("md_busy",  hif.md_busy,  e.busy);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    bit s;
    rst_n = 1'b0;
    cyc = 0;
    model_reset();
    cur = nop();
    cur_stall = 1'b0;
    busy_cnt = 0;
    dut_stall_cnt = 0;
    drive(nop());

    repeat (3) step(alu(3, 3, 3), s);
    chk("rst_hold_stall", hif.stall, 0);
    #2 rst_n = 1'b1;
    nops(3);

    // ALU -> branch
    issue(alu(8, 1, 2), n);
    issue(beq(8, 9), n);
    chk("alu_beq_stalls", n, 1);
    nops(4);
    // lw -> ALU
    issue(lw(5, 1), n);
    issue(alu(6, 7, 5), n);
    chk("lw_alu_stalls", n, 1);
    nops(4);
    // lw -> branch
    issue(lw(9, 2), n);
    issue(beq(9, 9), n);
    chk("lw_beq_stalls", n, 2);
    nops(4);
    // jal -> jr
    issue(jal(), n);
    issue(jr(31), n);
    chk("jal_jr_stalls", n, 0);
    nops(4);
    // lw -> sw data
    issue(lw(9, 3), n);
    issue(sw(9, 4), n);
    chk("lw_sw_stalls", n, 0);
    nops(4);
    // $0 never creates a dependency
    issue(ori(0, 0), n);
    issue(beq(0, 0), n);
    chk("r0_beq_stalls", n, 0);
    nops(4);
    // mult -> mflo
    busy_cnt = 0;
    issue(mdop(1'b0), n);
    issue(mflo(2), n);
    chk("mult_mflo_stalls", n, 1 + NMULT);
    nops(12);
    chk("mult_busy_cycles", busy_cnt, NMULT);
    // div -> mflo
    busy_cnt = 0;
    issue(mdop(1'b1), n);
    issue(mflo(2), n);
    chk("div_mflo_stalls", n, 1 + NDIV);
    nops(14);
    chk("div_busy_cycles", busy_cnt, NDIV);

    // Reset in the middle of a lw -> beq stall
    issue(lw(9, 1), n);
    step(beq(9, 9), s);
    chk("pre_rst_stall", hif.stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall",    hif.stall,    0);
    chk("rst_md_busy",  hif.md_busy,  0);
    chk("rst_fwd_rs_d", hif.fwd_rs_d, 0);
    chk("rst_fwd_rt_d", hif.fwd_rt_d, 0);
    chk("rst_fwd_rs_e", hif.fwd_rs_e, 0);
    chk("rst_fwd_rt_e", hif.fwd_rt_e, 0);
    chk("rst_fwd_rt_m", hif.fwd_rt_m, 0);
    model_reset();
    exp_q.delete();
    cur_stall = 1'b0;
    repeat (2) step(nop(), s);
    #2 rst_n = 1'b1;
    nops(6);

    // Randomized traffic against the model
    for (int r = 0; r < 1500; r++) issue(rand_instr(), n);
    nops(6);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
